// File: rtl/dac_frame_scheduler.sv
// Round-robin arbiter and serializer: packs DDS channel A/B samples into
// header-prefixed command frames and shifts them MSB-first to a serial DAC.
module dac_frame_scheduler #(
   parameter int M       = 12,
   parameter int CLK_DIV = 2,
   parameter int GAP     = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [M-1:0] a_data,
   input  logic         a_valid,
   output logic         a_ready,
   input  logic [M-1:0] b_data,
   input  logic         b_valid,
   output logic         b_ready,
   input  logic         cfg_buf,
   input  logic         cfg_ga_n,
   input  logic         cfg_shdn_n,
   output logic         sclk,
   output logic         sdi,
   output logic         cs_n,
   output logic         busy,
   output logic         frame_done
);

   localparam int F     = M + 4;
   localparam int BIT_W = $clog2(F);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(F - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t           state;
   logic             last;
   logic             phase;
   logic [BIT_W-1:0] bit_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [F-1:0]     shreg;
   logic             grant_a;
   logic             grant_b;
   logic             bit_end;

   // Grant only from IDLE; on a tie the channel that did not go last wins.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (rst_n && state == S_IDLE && en) begin
         if (a_valid && (!b_valid || last))
            grant_a = 1'b1;
         else if (b_valid)
            grant_b = 1'b1;
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;
   assign bit_end = (state == S_SHIFT) && phase && (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cs_n       <= 1'b1;
         sclk       <= 1'b0;
         sdi        <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         last       <= 1'b1;
         phase      <= 1'b0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         gap_cnt    <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_a || grant_b) begin
                  state   <= S_SHIFT;
                  cs_n    <= 1'b0;
                  sclk    <= 1'b0;
                  sdi     <= grant_b;
                  busy    <= 1'b1;
                  last    <= grant_b;
                  phase   <= 1'b0;
                  bit_cnt <= '0;
                  div_cnt <= '0;
               end
            end
            S_SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!phase) begin
                     phase <= 1'b1;
                     sclk  <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     sclk  <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        state      <= S_GAP;
                        cs_n       <= 1'b1;
                        sdi        <= 1'b0;
                        frame_done <= 1'b1;
                        gap_cnt    <= '0;
                     end else begin
                        // Next bit appears on sdi while sclk is back low.
                        bit_cnt <= bit_cnt + 1'b1;
                        sdi     <= shreg[F-2];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Frame payload needs no reset: it is loaded on every accept.
   always_ff @(posedge clk) begin
      if (grant_a || grant_b)
         shreg <= {grant_b, cfg_buf, cfg_ga_n, cfg_shdn_n, grant_b ? b_data : a_data};
      else if (bit_end)
         shreg <= {shreg[F-2:0], 1'b0};
   end

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Bench for dac_frame_scheduler: timing-based reference model, frame decoder,
// table-driven header vectors, directed corner sequences and random traffic.
module tb_dac_frame_scheduler;

   localparam int M   = 12;
   localparam int CD  = 2;
   localparam int GP  = 2;
   localparam int F   = M + 4;
   localparam int PER = 1 + 2 * CD * F + GP;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, en, a_valid, b_valid, cfg_buf, cfg_ga_n, cfg_shdn_n;
   logic [M-1:0]  a_data, b_data;
   logic          a_ready, b_ready, sclk, sdi, cs_n, busy, frame_done;

   logic          en2, a_valid2, b_valid2;
   logic [M-1:0]  a_data2, b_data2;
   logic          a_ready2, b_ready2, sclk2, sdi2, cs2, busy2, fd2;

   dac_frame_scheduler #(.M(M), .CLK_DIV(CD), .GAP(GP)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
      .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
      .cfg_buf(cfg_buf), .cfg_ga_n(cfg_ga_n), .cfg_shdn_n(cfg_shdn_n),
      .sclk(sclk), .sdi(sdi), .cs_n(cs_n), .busy(busy), .frame_done(frame_done));

   dac_frame_scheduler #(.M(M), .CLK_DIV(1), .GAP(1)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en2),
      .a_data(a_data2), .a_valid(a_valid2), .a_ready(a_ready2),
      .b_data(b_data2), .b_valid(b_valid2), .b_ready(b_ready2),
      .cfg_buf(1'b0), .cfg_ga_n(1'b1), .cfg_shdn_n(1'b1),
      .sclk(sclk2), .sdi(sdi2), .cs_n(cs2), .busy(busy2), .frame_done(fd2));

   int total = 0;
   int bad   = 0;
   int pc    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, pc);
      end
   endtask

   always @(posedge clk) pc++;

   // Reference model: a frame is described only by its accept edge and its
   // 16-bit word; every pin follows from the elapsed cycle count.
   bit          m_known = 1'b0;
   bit          m_act   = 1'b0;
   bit          m_last  = 1'b1;
   int          m_s     = 0;
   logic [15:0] m_frame = '0;
   int          k;
   logic        e_cs, e_sc, e_sd, e_bz, e_fd, e_idle, e_ra, e_rb;

   always @(negedge clk) begin
      e_ra = 1'b0;
      e_rb = 1'b0;
      if (m_known) begin
         k = pc - m_s;
         e_cs = 1'b1; e_sc = 1'b0; e_sd = 1'b0; e_bz = 1'b0; e_fd = 1'b0; e_idle = 1'b1;
         if (m_act) begin
            if (k < 2 * CD * F) begin
               e_cs = 1'b0;
               e_sc = ((k % (2 * CD)) >= CD);
               e_sd = m_frame[F - 1 - k / (2 * CD)];
            end
            if (k == 2 * CD * F) e_fd = 1'b1;
            if (k < 2 * CD * F + GP) begin
               e_bz   = 1'b1;
               e_idle = 1'b0;
            end
         end
         e_ra = rst_n && e_idle && en && a_valid && (!b_valid || m_last);
         e_rb = rst_n && e_idle && en && b_valid && (!a_valid || !m_last);
         chk("a_ready", a_ready, e_ra);
         chk("b_ready", b_ready, e_rb);
         chk("cs_n", cs_n, e_cs);
         chk("sclk", sclk, e_sc);
         chk("sdi", sdi, e_sd);
         chk("busy", busy, e_bz);
         chk("frame_done", frame_done, e_fd);
      end
      if (!rst_n) begin
         m_known = 1'b1;
         m_act   = 1'b0;
         m_last  = 1'b1;
      end else if (m_known && (e_ra || e_rb)) begin
         m_act   = 1'b1;
         m_s     = pc + 1;
         m_last  = e_rb;
         m_frame = {e_rb, cfg_buf, cfg_ga_n, cfg_shdn_n, e_rb ? b_data : a_data};
      end
   end

   // Pin-level frame decoder for the default instance.
   logic        p_cs = 1'b1, p_sclk = 1'b0;
   logic [15:0] wsr = '0;
   int          nb = 0, lowc = 0;
   logic [15:0] cap_q[$];
   int          cnt_q[$];
   int          nb_q[$];
   int          fall_q[$];

   always @(negedge clk) begin
      if (p_cs === 1'b1 && cs_n === 1'b0) begin
         wsr = '0; nb = 0; lowc = 0;
         fall_q.push_back(pc);
      end
      if (cs_n === 1'b0) begin
         lowc++;
         if (sclk === 1'b1 && p_sclk !== 1'b1) begin
            wsr = {wsr[14:0], sdi};
            nb++;
         end
      end
      if (p_cs === 1'b0 && cs_n === 1'b1) begin
         cap_q.push_back(wsr);
         cnt_q.push_back(lowc);
         nb_q.push_back(nb);
      end
      p_cs   = cs_n;
      p_sclk = sclk;
   end

   // Timing monitor for the CLK_DIV=1, GAP=1 instance.
   logic p2_cs = 1'b1, p2_sclk = 1'b0;
   bit   first2 = 1'b1;
   int   low2 = 0, last_low2 = 0, fall2 = 0, per2 = 0, rise2 = 0, sper2 = 0;

   always @(negedge clk) begin
      if (p2_cs === 1'b1 && cs2 === 1'b0) begin
         per2 = pc - fall2; fall2 = pc; low2 = 0; first2 = 1'b1;
      end
      if (cs2 === 1'b0) begin
         low2++;
         if (sclk2 === 1'b1 && p2_sclk !== 1'b1) begin
            if (!first2) sper2 = pc - rise2;
            first2 = 1'b0;
            rise2  = pc;
         end
      end
      if (p2_cs === 1'b0 && cs2 === 1'b1) last_low2 = low2;
      p2_cs   = cs2;
      p2_sclk = sclk2;
   end

   task automatic clear_caps();
      cap_q.delete(); cnt_q.delete(); nb_q.delete(); fall_q.delete();
   endtask

   task automatic wait_frames(input int n, input string nm);
      int c = 0;
      while (cap_q.size() < n && c < PER * n + 200) begin
         @(negedge clk); #1;
         c++;
      end
      chk({nm, " frames seen"}, (cap_q.size() >= n), 1);
   endtask

   // Present one sample, hold valid until accepted, then drop it.
   task automatic send(input bit ch, input logic [M-1:0] d, input bit bf, input bit ga, input bit sh);
      int c = 0;
      bit got = 1'b0;
      cfg_buf = bf; cfg_ga_n = ga; cfg_shdn_n = sh;
      if (ch) begin b_data = d; b_valid = 1'b1; end
      else begin a_data = d; a_valid = 1'b1; end
      while (!got && c < 3 * PER) begin
         @(negedge clk);
         got = ch ? b_ready : a_ready;
         c++;
      end
      chk("handshake", got, 1);
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   typedef struct {
      bit          ch;
      logic [11:0] d;
      bit          bf, ga, sh;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[6];
   int   rdy_cnt;

   initial begin
      vecs[0] = '{1'b0, 12'hABC, 1'b0, 1'b1, 1'b1, 16'h3ABC};
      vecs[1] = '{1'b1, 12'h123, 1'b0, 1'b1, 1'b1, 16'hB123};
      vecs[2] = '{1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0, 16'h4FFF};
      vecs[3] = '{1'b1, 12'h000, 1'b1, 1'b1, 1'b1, 16'hF000};
      vecs[4] = '{1'b0, 12'h555, 1'b0, 1'b0, 1'b1, 16'h1555};
      vecs[5] = '{1'b1, 12'hAAA, 1'b1, 1'b0, 1'b0, 16'hCAAA};

      rst_n = 1'b0; en = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
      a_data = 12'hABC; b_data = 12'h123;
      cfg_buf = 1'b0; cfg_ga_n = 1'b1; cfg_shdn_n = 1'b1;
      en2 = 1'b1; a_valid2 = 1'b1; b_valid2 = 1'b0; a_data2 = 12'h800; b_data2 = '0;

      // Reset held with demand present.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst a_ready", a_ready, 0);
         chk("rst cs_n", cs_n, 1);
         chk("rst sclk", sclk, 0);
         chk("rst sdi", sdi, 0);
         chk("rst busy", busy, 0);
      end
      rst_n = 1'b1;

      // Both channels requesting: A first, then alternate.
      wait_frames(3, "rr");
      if (cap_q.size() >= 3) begin
         chk("rr word0", cap_q[0], 16'h3ABC);
         chk("rr word1", cap_q[1], 16'hB123);
         chk("rr word2", cap_q[2], 16'h3ABC);
         chk("rr spacing01", fall_q[1] - fall_q[0], PER);
         chk("rr spacing12", fall_q[2] - fall_q[1], PER);
         chk("rr cs_n low", cnt_q[0], 2 * CD * F);
      end
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (PER + 5) @(posedge clk);
      #1;
      clear_caps();

      // Header/data packing vectors, one isolated frame each.
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].ch, vecs[i].d, vecs[i].bf, vecs[i].ga, vecs[i].sh);
         wait_frames(1, "vec");
         if (cap_q.size() >= 1) begin
            chk($sformatf("vec%0d word", i), cap_q[0], vecs[i].exp);
            chk($sformatf("vec%0d bits", i), nb_q[0], F);
            chk($sformatf("vec%0d low", i), cnt_q[0], 2 * CD * F);
         end
         repeat (GP + 3) @(posedge clk);
         #1;
         clear_caps();
      end

      chk("div1 cs_n low", last_low2, 32);
      chk("div1 period", per2, 34);
      chk("div1 sclk period", sper2, 2);

      // en dropped mid-frame: frame completes, no new grants until en returns.
      send(1'b0, 12'h321, 1'b0, 1'b1, 1'b1);
      en = 1'b0; a_valid = 1'b1;
      wait_frames(1, "en");
      if (cap_q.size() >= 1) begin
         chk("en word", cap_q[0], 16'h3321);
         chk("en bits", nb_q[0], F);
      end
      rdy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (a_ready) rdy_cnt++;
      end
      chk("en0 ready count", rdy_cnt, 0);
      @(posedge clk); #1;
      en = 1'b1;
      @(negedge clk);
      chk("en resume ready", a_ready, 1);
      @(posedge clk); #1;
      a_valid = 1'b0;
      repeat (PER + 5) @(posedge clk);
      #1;
      clear_caps();

      // Reset during bit 7 aborts the frame; the next frame is intact.
      send(1'b0, 12'h777, 1'b1, 1'b1, 1'b1);
      begin
         int c = 0;
         while (!(nb == 7 && sclk === 1'b0 && cs_n === 1'b0) && c < PER) begin
            @(negedge clk);
            c++;
         end
         chk("reach bit7", (c < PER), 1);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst cs_n", cs_n, 1);
      chk("midrst sclk", sclk, 0);
      chk("midrst sdi", sdi, 0);
      chk("midrst busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_caps();
      send(1'b0, 12'h5A5, 1'b0, 1'b1, 1'b1);
      wait_frames(1, "midrst");
      if (cap_q.size() >= 1) begin
         chk("midrst word", cap_q[0], 16'h35A5);
         chk("midrst bits", nb_q[0], F);
         chk("midrst low", cnt_q[0], 2 * CD * F);
      end

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         a_valid    = ($urandom_range(0, 3) != 0);
         b_valid    = ($urandom_range(0, 3) != 0);
         en         = ($urandom_range(0, 9) != 0);
         a_data     = M'($urandom);
         b_data     = M'($urandom);
         cfg_buf    = 1'($urandom);
         cfg_ga_n   = 1'($urandom);
         cfg_shdn_n = 1'($urandom);
         rst_n      = ($urandom_range(0, 499) != 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      repeat (4) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dac_frame_scheduler.md
Name: dac_frame_scheduler

Overview:
Sequences the serial DAC link behind the DDS core. It accepts 12-bit waveform samples from two DDS channels (A, B) over valid/ready handshakes and grants the shared link round-robin. Each granted sample is packed into a 16-bit dual-DAC command frame (4 header bits + sample) and shifted out MSB-first with a generated serial clock and chip select. It sits between the DDS phase/waveform stages and the pad-level DAC pins, and replaces free-running serialization with framed, arbitrated transfers.

Parameters:
M, 12, sample width; frame width F = M+4.
CLK_DIV, 2, sclk half-period in clk cycles (>=1).
GAP, 2, clk cycles cs_n held high between frames (>=1).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
en  in  1  enable new grants; a frame in progress always completes.
a_data  in  M  channel A sample.
a_valid  in  1  channel A sample available.
a_ready  out  1  channel A sample accepted this cycle.
b_data  in  M  channel B sample.
b_valid  in  1  channel B sample available.
b_ready  out  1  channel B sample accepted this cycle.
cfg_buf  in  1  header BUF bit.
cfg_ga_n  in  1  header GA_n bit (1 = gain x1).
cfg_shdn_n  in  1  header SHDN_n bit (1 = active).
sclk  out  1  serial clock to DAC, idles low.
sdi  out  1  serial data, MSB first.
cs_n  out  1  frame select, active-low.
busy  out  1  high whenever state != IDLE.
frame_done  out  1  one-cycle pulse on entry to GAP.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n low at a rising edge): state=IDLE, cs_n=1, sclk=0, sdi=0, busy=0, frame_done=0, a_ready=b_ready=0 combinationally, round-robin pointer last=B (A wins first tie). Reset mid-frame aborts immediately; no partial-frame completion.
- States: IDLE, SHIFT, GAP.
- IDLE: grant = en & (a_valid|b_valid). Only one valid -> that channel; both valid -> channel != last. a_ready/b_ready are combinational, high only in IDLE for the granted channel. On the accept edge: shift register <= {ch, cfg_buf, cfg_ga_n, cfg_shdn_n, data} with ch=0 for A, 1 for B; last <= granted channel; bit counter <= 0; div counter <= 0; -> SHIFT. Header config is sampled only at accept.
- SHIFT: cs_n=0; sdi = shift[F-1] from the first SHIFT cycle. Each bit = CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high; the DAC samples on sclk rising. At the end of each high phase, sclk returns low and the register shifts left by 1 (sdi changes only while sclk is low). After the high phase of bit F-1: -> GAP, sclk=0, cs_n=1, sdi=0.
- cs_n is low exactly 2*CLK_DIV*F cycles per frame. The accept edge is at cycle t; cs_n falls at t+1.
- GAP: cs_n=1, sclk=0. frame_done is high in the first GAP cycle. After GAP cycles -> IDLE.
- Frame period under continuous demand: 1 + 2*CLK_DIV*F + GAP clk cycles (67 at defaults).
- en low: no grants in IDLE, and ready stays 0. It has no effect on a frame already in SHIFT or GAP.
- A valid that drops before being granted is ignored. Data is never latched without a ready/valid handshake on the same cycle.
- Simultaneous reset and grant: reset wins; no handshake occurs.

Test Plan:
- Reset: rst_n low 3 cycles with a_valid=1 -> a_ready=0, cs_n=1, sclk=0, sdi=0, busy=0. After release, the first grant goes to A.
- Single A frame, defaults: a_data=0xABC, cfg_buf=0, ga_n=1, shdn_n=1 -> a_ready for 1 cycle. cs_n low 64 cycles. sdi bits on 16 sclk rises = 0x3ABC. frame_done pulse 1 cycle, then cs_n high 2 cycles.
- Round-robin: a_valid=b_valid=1 held, b_data=0x123 -> frames alternate A, B, A. The B frame reads 0xB123. Grant-to-grant spacing is 67 cycles.
- en=0 mid-frame: the current frame completes all 16 bits, then no further ready while en=0. Resumes within 1 cycle of en=1 in IDLE.
- Reset mid-frame: rst_n low during bit 7 -> next edge cs_n=1, sclk=0, state IDLE. The next frame starts cleanly with the MSB header bit.
- CLK_DIV=1, GAP=1: sclk period 2 clk, cs_n low 32 cycles, period 34 cycles.
